// File: rtl/port_input_responder_pkg.sv
// -----------------------------------------------------------------------------
// port_input_responder_pkg
//   Shared constants for the CPU input-port responder: bus word size, board
//   input widths and the register offsets decoded relative to the block's
//   base address.
// -----------------------------------------------------------------------------
package port_input_responder_pkg;

   localparam int WORD_SIZE = 16;
   localparam int SW_W      = 8;
   localparam int N_BTN     = 4;

   // Register offsets from the block's base address.
   typedef enum logic [1:0] {
      PIN_SW  = 2'd0,   // R : synchronised switches
      PIN_BTN = 2'd1,   // R : debounced button levels
      PIN_EVT = 2'd2,   // R : sticky press flags, read clears; W : write-1-to-clear
      PIN_CNT = 2'd3    // R : press counter; W : any write clears
   } pin_reg_e;

   localparam logic [WORD_SIZE-1:0] PORT_IN_SPAN = WORD_SIZE'(4);

endpackage : port_input_responder_pkg

// File: rtl/port_input_responder_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   One button channel: 2-FF synchroniser followed by a stability counter.
//   The accepted level only follows the synchronised input after it has
//   disagreed with the current level for DEBOUNCE_CYCLES consecutive cycles.
//   A level change is visible DEBOUNCE_CYCLES+2 cycles after the pin moves.
// Ports
//   clk    in  1  system clock
//   rst_n  in  1  asynchronous active-low reset
//   raw    in  1  raw (asynchronous, bouncing) button pin
//   level  out 1  debounced level
//   rise   out 1  one-cycle pulse, coincident with level going 0->1
// -----------------------------------------------------------------------------
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 18
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_meta;
   logic             sync_q;
   logic [CNT_W-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of its neighbours (the synchroniser depends on it).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta <= 1'b0;
         sync_q    <= 1'b0;
         cnt       <= '0;
         level     <= 1'b0;
         rise      <= 1'b0;
      end else begin
         sync_meta <= raw;
         sync_q    <= sync_meta;
         rise      <= 1'b0;
         if (sync_q == level) begin
            // Input agrees with the accepted level (or bounced back): restart.
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync_q;
            rise  <= sync_q;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule : btn_debounce

// File: rtl/port_input_responder.sv
// -----------------------------------------------------------------------------
// port_input_responder
//   CPU I/O-port read responder. Decodes four consecutive port addresses from
//   BASE_ADDR and answers portget with switch, button-level, press-event and
//   press-count data on a registered portout. Board switches are synchronised,
//   buttons are synchronised and debounced.
// Ports
//   clk       in  1          system clock
//   rst_n     in  1          asynchronous active-low reset
//   sw        in  8          raw board switches
//   btn       in  4          raw board buttons (bouncing)
//   portaddr  in  WORD_SIZE  CPU port address
//   portget   in  1          CPU port read strobe (one cycle)
//   portset   in  1          CPU port write strobe (one cycle)
//   portval   in  WORD_SIZE  CPU port write data
//   portout   out WORD_SIZE  read data, valid the cycle after portget, held
//   btn_lvl   out 4          debounced button levels
// -----------------------------------------------------------------------------
module port_input_responder
   import port_input_responder_pkg::*;
#(
   parameter logic [WORD_SIZE-1:0] BASE_ADDR       = 16'h0010,
   parameter int                   DEBOUNCE_CYCLES = 250000,
   parameter int                   CNT_W           = 18
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [SW_W-1:0]      sw,
   input  logic [N_BTN-1:0]     btn,
   input  logic [WORD_SIZE-1:0] portaddr,
   input  logic                 portget,
   input  logic                 portset,
   input  logic [WORD_SIZE-1:0] portval,
   output logic [WORD_SIZE-1:0] portout,
   output logic [N_BTN-1:0]     btn_lvl
);

   logic [SW_W-1:0]      sw_meta;
   logic [SW_W-1:0]      sw_sync;
   logic [N_BTN-1:0]     rise;
   logic [N_BTN-1:0]     evt;
   logic [N_BTN-1:0]     evt_next;
   logic [WORD_SIZE-1:0] press_count;
   logic [WORD_SIZE-1:0] count_next;
   logic [WORD_SIZE-1:0] offset;
   logic                 hit;
   pin_reg_e             reg_sel;
   logic                 rd_evt;
   logic                 wr_evt;
   logic                 wr_cnt;
   logic [WORD_SIZE-1:0] read_data;

   // Only the low nibble of write data is meaningful here.
   logic unused_portval;
   assign unused_portval = ^portval[WORD_SIZE-1:N_BTN];

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_debounce (
         .clk   (clk),
         .rst_n (rst_n),
         .raw   (btn[i]),
         .level (btn_lvl[i]),
         .rise  (rise[i])
      );
   end

   // NOTE: every signal written below gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      offset  = portaddr - BASE_ADDR;   // wraps large when below BASE_ADDR
      hit     = (offset < PORT_IN_SPAN);
      reg_sel = pin_reg_e'(offset[1:0]);
      rd_evt  = portget && hit && (reg_sel == PIN_EVT);
      wr_evt  = portset && hit && (reg_sel == PIN_EVT);
      wr_cnt  = portset && hit && (reg_sel == PIN_CNT);

      read_data = '0;
      if (hit) begin
         case (reg_sel)
            PIN_SW:  read_data = WORD_SIZE'(sw_sync);
            PIN_BTN: read_data = WORD_SIZE'(btn_lvl);
            PIN_EVT: read_data = WORD_SIZE'(evt);
            PIN_CNT: read_data = press_count;
            default: read_data = '0;
         endcase
      end

      // Clears first, then new edges: a concurrent rising edge keeps its bit set.
      evt_next = evt;
      if (rd_evt) evt_next = '0;
      if (wr_evt) evt_next = evt_next & ~portval[N_BTN-1:0];
      evt_next = evt_next | rise;

      // Clear first, then count: clear concurrent with an edge leaves 1.
      count_next = wr_cnt ? '0 : press_count;
      if (|rise) count_next = count_next + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_meta     <= '0;
         sw_sync     <= '0;
         evt         <= '0;
         press_count <= '0;
         portout     <= '0;
      end else begin
         sw_meta     <= sw;
         sw_sync     <= sw_meta;
         evt         <= evt_next;
         press_count <= count_next;
         // read_data is built from pre-update state, so a same-cycle write
         // is not yet visible in the returned value.
         if (portget) portout <= read_data;
      end
   end

endmodule : port_input_responder

// File: tb/tb_port_input_responder.sv
// -----------------------------------------------------------------------------
// tb_port_input_responder
//   Self-checking bench for port_input_responder with a short debounce window.
//   Port reads push their expected value to a scoreboard queue; a monitor pops
//   and compares when portout becomes valid.
// -----------------------------------------------------------------------------
module tb_port_input_responder;

   localparam int DEB = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  sw = '0;
   logic [3:0]  btn = '0;
   logic [15:0] portaddr = '0;
   logic        portget = 1'b0;
   logic        portset = 1'b0;
   logic [15:0] portval = '0;
   logic [15:0] portout;
   logic [3:0]  btn_lvl;

   int n_checks = 0;
   int n_fails  = 0;
   int tag_n    = 0;

   port_input_responder #(
      .BASE_ADDR       (16'h0010),
      .DEBOUNCE_CYCLES (DEB),
      .CNT_W           (18)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sw       (sw),
      .btn      (btn),
      .portaddr (portaddr),
      .portget  (portget),
      .portset  (portset),
      .portval  (portval),
      .portout  (portout),
      .btn_lvl  (btn_lvl)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [15:0] exp;
      logic [7:0]  tag;
   } rd_exp_t;

   rd_exp_t sb_q[$];
   logic    get_d;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) get_d <= 1'b0;
      else        get_d <= portget;
   end

   always @(negedge clk) begin
      if (get_d) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL sb_underflow: read data with no expected value");
         end else begin
            rd_exp_t e;
            e = sb_q.pop_front();
            check($sformatf("read#%0d", e.tag), {16'h0, portout}, {16'h0, e.exp});
         end
      end
   end

   // ---------------- bus helpers (called at a negedge) ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_read(input logic [15:0] a, input logic [15:0] e);
      portaddr = a;
      portget  = 1'b1;
      sb_q.push_back('{exp: e, tag: tag_n[7:0]});
      tag_n++;
      @(negedge clk);
      portget = 1'b0;
   endtask

   task automatic do_write(input logic [15:0] a, input logic [15:0] v);
      portaddr = a;
      portval  = v;
      portset  = 1'b1;
      @(negedge clk);
      portset  = 1'b0;
   endtask

   task automatic do_rw(input logic [15:0] a, input logic [15:0] v, input logic [15:0] e);
      portaddr = a;
      portval  = v;
      portget  = 1'b1;
      portset  = 1'b1;
      sb_q.push_back('{exp: e, tag: tag_n[7:0]});
      tag_n++;
      @(negedge clk);
      portget = 1'b0;
      portset = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [15:0] addr;
      logic [7:0]  sw;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[9];

   initial begin
      logic [3:0] bounce [4];

      vecs[0] = '{16'h0010, 8'hA5, 16'h00A5};
      vecs[1] = '{16'h0020, 8'hFF, 16'h0000};   // unmapped clears portout
      vecs[2] = '{16'h0010, 8'h3C, 16'h003C};
      vecs[3] = '{16'h0014, 8'h81, 16'h0000};   // one past the top
      vecs[4] = '{16'h0010, 8'h5A, 16'h005A};
      vecs[5] = '{16'h000F, 8'h00, 16'h0000};   // one below the base
      vecs[6] = '{16'h0011, 8'h7E, 16'h0000};   // no buttons yet
      vecs[7] = '{16'h0012, 8'hC3, 16'h0000};
      vecs[8] = '{16'h0013, 8'h18, 16'h0000};

      // Reset state
      #12;
      check("reset_portout", {16'h0, portout}, 32'h0);
      check("reset_btn_lvl", {28'h0, btn_lvl}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick(1);

      // Table-driven switch reads and address decode
      for (int i = 0; i < 9; i++) begin
         sw = vecs[i].sw;
         tick(3);
         do_read(vecs[i].addr, vecs[i].exp);
      end

      // btn[1] bounces 0/1/0/1 at 2-cycle spacing, then holds 1
      bounce[0] = 4'b0010; bounce[1] = 4'b0000; bounce[2] = 4'b0010; bounce[3] = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         btn = bounce[k];
         repeat (2) begin
            @(negedge clk);
            check("bounce_no_level", {28'h0, btn_lvl}, 32'h0);
         end
      end
      btn = 4'b0010;
      for (int c = 1; c <= DEB + 2; c++) begin
         @(negedge clk);
         check($sformatf("settle_c%0d", c), {28'h0, btn_lvl},
               (c < DEB + 2) ? 32'h0 : 32'h2);
      end
      tick(2);
      do_read(16'h0011, 16'h0002);
      do_read(16'h0013, 16'h0001);
      do_read(16'h0012, 16'h0002);
      do_read(16'h0012, 16'h0000);   // read cleared the flags

      // Simultaneous btn[0] and btn[2] presses count once
      btn = 4'b0111;
      tick(DEB + 4);
      check("lvl_0111", {28'h0, btn_lvl}, 32'h7);
      do_read(16'h0012, 16'h0005);
      do_read(16'h0012, 16'h0000);
      do_read(16'h0013, 16'h0002);

      // W1C on bit 0 in the same cycle btn[0] re-rises: set wins
      btn = 4'b0010; tick(DEB + 4);
      btn = 4'b0111; tick(DEB + 4);  // evt = 0101, count = 3
      btn = 4'b0110; tick(DEB + 4);
      btn = 4'b0111; tick(DEB + 2);  // rise pulse is live at the next posedge
      do_write(16'h0012, 16'h0001);
      do_read(16'h0012, 16'h0005);   // count = 4

      // Counter clear concurrent with an edge -> 1; plain W1C on bit 3
      btn = 4'b1111; tick(DEB + 2);
      do_write(16'h0013, 16'h0000);
      do_read(16'h0013, 16'h0001);
      do_write(16'h0012, 16'h0008);
      do_read(16'h0012, 16'h0000);
      // Read and write in the same cycle return the pre-write value
      do_rw(16'h0013, 16'hBEEF, 16'h0001);
      do_read(16'h0013, 16'h0000);
      do_write(16'h0010, 16'h1234);  // read-only register, ignored
      do_read(16'h0010, {8'h00, vecs[8].sw});

      // press_count wrap FFFF -> 0
      btn = 4'b0111; tick(DEB + 4);
      force dut.press_count = 16'hFFFF;
      @(negedge clk);
      release dut.press_count;
      do_read(16'h0013, 16'hFFFF);
      btn = 4'b1111; tick(DEB + 4);
      do_read(16'h0013, 16'h0000);
      do_read(16'h0011, 16'h000F);

      // Reset asserted mid-debounce of btn[3] release
      btn = 4'b0111;
      tick(3);
      #2 rst_n = 1'b0;
      #1;
      check("rst_btn_lvl", {28'h0, btn_lvl}, 32'h0);
      check("rst_portout", {16'h0, portout}, 32'h0);
      tick(3);
      rst_n = 1'b1;
      for (int c = 1; c <= DEB + 2; c++) begin
         @(negedge clk);
         check($sformatf("post_rst_c%0d", c), {28'h0, btn_lvl},
               (c < DEB + 2) ? 32'h0 : 32'h7);
      end
      tick(2);
      do_read(16'h0012, 16'h0007);
      do_read(16'h0013, 16'h0001);

      tick(3);
      check("sb_drained", sb_q.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule : tb_port_input_responder
